hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Parametrised hazard and forwarding controller for an N-stage RISC-V pipeline; successor to the fixed 3-stage forwarding logic in the core controller.
- Tracks destination-register metadata for every in-flight instruction from EX (stage 1) to WB (stage DEPTH).
- Produces per-operand forwarding selects, a load-use stall, a branch-redirect flush, WB regfile write-through bypass, and stall/flush event counters.
- Sits beside the controller and drives the datapath forwarding muxes and the IF/decode/EX enables.

Parameters:
- DEPTH, 3, number of tracked stages (EX..WB). Legal range 2..8.
- REG_AW, 5, register-address width.
- LOAD_READY, 3, lowest stage index at which load data can be forwarded. Legal range 2..DEPTH.
- SELW, $clog2(DEPTH+1), forwarding-select width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dec_valid  in  1  decode holds a real instruction
- dec_rs1, dec_rs2  in  REG_AW  decode source registers
- dec_uses_rs1, dec_uses_rs2  in  1  decode instruction reads that source
- dec_rd  in  REG_AW  decode destination register
- dec_wen  in  1  decode instruction writes rd
- dec_is_load  in  1  decode instruction is a load
- redirect  in  1  branch/jump taken, resolved in EX this cycle
- ex_fwd_a, ex_fwd_b  out  SELW  EX operand source: 0 = pipeline register; s in 2..DEPTH = result of stage s
- dec_byp_a, dec_byp_b  out  1  decode read must take the WB write data
- stall  out  1  freeze IF, decode and EX; insert bubble into stage 2
- flush_dec  out  1  kill the instruction currently in decode
- stall_count, flush_count  out  32  event counters

Behaviour:
- Per-stage state for s = 1..DEPTH: valid, rd, wen, is_load. Stage 1 also holds rs1, rs2, uses_rs1, uses_rs2.
- Reset (synchronous): all stage valid bits = 0, counters = 0. All outputs therefore read 0 in the cycle after rst is sampled. This includes reset asserted mid-stall.
- match(s, r): true when valid[s] && wen[s] && rd[s] == r && r != 0. Writes to x0 never match.
- ex_fwd_a: if stage1 valid and uses_rs1, the smallest s in 2..DEPTH with match(s, rs1); otherwise 0. Youngest producer wins. Purely combinational from state. ex_fwd_b is the same using rs2.
- stall: 1 when the youngest match for either used EX operand is at stage s with is_load[s] and s < LOAD_READY.
  - Non-load producers are always forwardable from stage 2 onward.
  - Combinational output.
- dec_byp_a: dec_valid && dec_uses_rs1 && match(DEPTH, dec_rs1). dec_byp_b is the same using rs2.
- flush_dec = redirect && !stall. A redirect during a stall is ignored; EX cannot resolve a branch while its operand is not ready.
- Clock edge, when not in reset:
  - Stages 2..DEPTH always advance: stage s+1 <= stage s for s >= 2.
  - If stall: stage 2 <= bubble (valid = 0); stage 1 holds.
  - Else: stage 2 <= stage 1.
    - Stage 1 <= decode inputs, with valid = dec_valid && !flush_dec.
    - On flush, stage 1 valid = 0 and all other fields are don't-care.
- Stage DEPTH retires each cycle; there is no back-pressure from WB.
- Counters: stall_count += 1 on every cycle with stall = 1; flush_count += 1 on every cycle with flush_dec = 1. Both wrap modulo 2^32.
- Latency:
  - Forward selects, stall and flush_dec are zero-cycle combinational from current state.
  - State updates take effect one cycle later.

Test Plan (DEPTH=3, LOAD_READY=3):
- ALU-ALU back-to-back: add x5,x1,x2 then add x6,x5,x3 with consumer in EX and producer in stage 2 -> ex_fwd_a=2, ex_fwd_b=0, stall=0.
- Load-use: lw x5 then add x6,x5,x0 -> stall=1 for exactly one cycle and stage 2 bubble; next cycle ex_fwd_a=3, stall=0, stall_count=1.
- x0 and priority:
  - addi x0 then use x0 -> ex_fwd_a=0.
  - x5 written by the instructions in stages 2 and 3 -> ex_fwd_a=2.
- Redirect: redirect=1 with stall=0 -> flush_dec=1; next cycle stage 1 invalid, ex_fwd_a=0, flush_count=1. Redirect during stall -> flush_dec=0, flush_count unchanged.
- WB bypass: stage 3 holds wen=1, rd=x7; decode has rs2=x7, uses_rs2=1 -> dec_byp_b=1, dec_byp_a=0. Same with rd=x0 -> both 0.
- Reset mid-stall: assert rst during a load-use stall -> next cycle stall=0, all ex_fwd=0, counters=0, all stages invalid.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard and forwarding controller for an N-stage in-order pipeline.
// Tracks destination-register metadata for every in-flight instruction
// from EX (stage 1) to WB (stage DEPTH) and derives operand forwarding
// selects, the load-use stall, the redirect flush of decode, the WB
// write-through bypass for decode reads, and stall/flush event counters.
//
// Timing contract: ex_fwd_*, stall, flush_dec and dec_byp_* are purely
// combinational from the current stage state (plus decode/redirect inputs);
// state changes made on a clock edge become visible in the next cycle.
module hazard_unit #(
   parameter int DEPTH      = 3,
   parameter int REG_AW     = 5,
   parameter int LOAD_READY = 3,
   parameter int SELW       = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic              dec_uses_rs1,
   input  logic              dec_uses_rs2,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_wen,
   input  logic              dec_is_load,
   input  logic              redirect,
   output logic [SELW-1:0]   ex_fwd_a,
   output logic [SELW-1:0]   ex_fwd_b,
   output logic              dec_byp_a,
   output logic              dec_byp_b,
   output logic              stall,
   output logic              flush_dec,
   output logic [31:0]       stall_count,
   output logic [31:0]       flush_count
);

   // Per-stage destination metadata, stage 1 = EX, stage DEPTH = WB.
   logic              r_valid   [1:DEPTH];
   logic [REG_AW-1:0] r_rd      [1:DEPTH];
   logic              r_wen     [1:DEPTH];
   logic              r_is_load [1:DEPTH];

   // Source operands of the instruction currently in EX.
   logic [REG_AW-1:0] r_rs1;
   logic [REG_AW-1:0] r_rs2;
   logic              r_uses_rs1;
   logic              r_uses_rs2;

   logic [31:0]       r_stall_count;
   logic [31:0]       r_flush_count;

   // Per-stage producer hits for each EX operand (stages 2..DEPTH).
   logic [DEPTH:2]    w_hit_a;
   logic [DEPTH:2]    w_hit_b;
   logic [SELW-1:0]   w_sel_a;
   logic [SELW-1:0]   w_sel_b;
   logic              w_late_a;
   logic              w_late_b;
   logic              w_stall;
   logic              w_flush;
   logic              w_wb_hit_a;
   logic              w_wb_hit_b;

   // A stage produces a register when it is live, writes, targets it, and
   // the target is not x0 (writes to x0 are architecturally discarded).
   always_comb begin
      w_hit_a = '0;
      w_hit_b = '0;
      for (int s = 2; s <= DEPTH; s++) begin
         w_hit_a[s] = r_valid[s] && r_wen[s] && (r_rd[s] == r_rs1) && (r_rs1 != '0);
         w_hit_b[s] = r_valid[s] && r_wen[s] && (r_rd[s] == r_rs2) && (r_rs2 != '0);
      end
   end

   // Pick the youngest producer per operand; scanning oldest-to-youngest
   // lets the last hit overwrite, so the smallest stage index wins. A load
   // that has not yet reached LOAD_READY cannot supply its data.
   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_late_a = 1'b0;
      w_late_b = 1'b0;
      for (int s = DEPTH; s >= 2; s--) begin
         if (r_valid[1] && r_uses_rs1 && w_hit_a[s]) begin
            w_sel_a  = SELW'(s);
            w_late_a = r_is_load[s] && (s < LOAD_READY);
         end
         if (r_valid[1] && r_uses_rs2 && w_hit_b[s]) begin
            w_sel_b  = SELW'(s);
            w_late_b = r_is_load[s] && (s < LOAD_READY);
         end
      end
   end

   // Stall, flush and WB bypass decisions. A redirect cannot be trusted
   // while EX is waiting on an operand, so it is suppressed during a stall.
   always_comb begin
      w_stall    = w_late_a || w_late_b;
      w_flush    = redirect && !w_stall;
      w_wb_hit_a = r_valid[DEPTH] && r_wen[DEPTH] && (r_rd[DEPTH] == dec_rs1) && (dec_rs1 != '0);
      w_wb_hit_b = r_valid[DEPTH] && r_wen[DEPTH] && (r_rd[DEPTH] == dec_rs2) && (dec_rs2 != '0);
   end

   // Drive the outputs from the combinational decisions and counters.
   always_comb begin
      ex_fwd_a    = w_sel_a;
      ex_fwd_b    = w_sel_b;
      stall       = w_stall;
      flush_dec   = w_flush;
      dec_byp_a   = dec_valid && dec_uses_rs1 && w_wb_hit_a;
      dec_byp_b   = dec_valid && dec_uses_rs2 && w_wb_hit_b;
      stall_count = r_stall_count;
      flush_count = r_flush_count;
   end

   // Stage valid bits: older stages always shift, stage 2 takes a bubble on
   // stall, stage 1 holds on stall and otherwise loads decode (killed on flush).
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 1; s <= DEPTH; s++) begin
            r_valid[s] <= 1'b0;
         end
      end else begin
         for (int s = DEPTH; s >= 3; s--) begin
            r_valid[s] <= r_valid[s-1];
         end
         if (w_stall) begin
            r_valid[2] <= 1'b0;
         end else begin
            r_valid[2] <= r_valid[1];
            r_valid[1] <= dec_valid && !w_flush;
         end
      end
   end

   // Stage payload fields; their content is irrelevant while the matching
   // valid bit is low, so they need no reset.
   always_ff @(posedge clk) begin
      for (int s = DEPTH; s >= 3; s--) begin
         r_rd[s]      <= r_rd[s-1];
         r_wen[s]     <= r_wen[s-1];
         r_is_load[s] <= r_is_load[s-1];
      end
      if (!w_stall) begin
         r_rd[2]      <= r_rd[1];
         r_wen[2]     <= r_wen[1];
         r_is_load[2] <= r_is_load[1];
         r_rd[1]      <= dec_rd;
         r_wen[1]     <= dec_wen;
         r_is_load[1] <= dec_is_load;
         r_rs1        <= dec_rs1;
         r_rs2        <= dec_rs2;
         r_uses_rs1   <= dec_uses_rs1;
         r_uses_rs2   <= dec_uses_rs2;
      end
   end

   // Event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
         if (w_flush) begin
            r_flush_count <= r_flush_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Directed plan scenarios followed by randomized traffic, every cycle
// compared against an instruction-level model of the pipeline.
module tb_hazard_unit;

   localparam int DEPTH      = 3;
   localparam int REG_AW     = 5;
   localparam int LOAD_READY = 3;
   localparam int SELW       = $clog2(DEPTH + 1);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              dec_valid;
   logic [REG_AW-1:0] dec_rs1;
   logic [REG_AW-1:0] dec_rs2;
   logic              dec_uses_rs1;
   logic              dec_uses_rs2;
   logic [REG_AW-1:0] dec_rd;
   logic              dec_wen;
   logic              dec_is_load;
   logic              redirect;
   logic [SELW-1:0]   ex_fwd_a;
   logic [SELW-1:0]   ex_fwd_b;
   logic              dec_byp_a;
   logic              dec_byp_b;
   logic              stall;
   logic              flush_dec;
   logic [31:0]       stall_count;
   logic [31:0]       flush_count;

   hazard_unit #(
      .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_READY(LOAD_READY)
   ) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
      .dec_rd(dec_rd), .dec_wen(dec_wen), .dec_is_load(dec_is_load),
      .redirect(redirect),
      .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
      .dec_byp_a(dec_byp_a), .dec_byp_b(dec_byp_b),
      .stall(stall), .flush_dec(flush_dec),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // ---------------- reference model ----------------
   // One record per in-flight instruction; pipe[s] is the instruction in stage s.
   typedef struct {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              wen;
      logic              ld;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              u1;
      logic              u2;
   } ins_t;

   ins_t        pipe [1:DEPTH];
   int unsigned m_stall_cnt;
   int unsigned m_flush_cnt;
   logic        e_stall;
   logic        e_flush;
   int          n_vec;
   int          n_fail;

   // Smallest stage in lo..hi whose instruction writes register r (x0 never), else 0.
   function automatic int producer(logic [REG_AW-1:0] r, int lo, int hi);
      for (int s = lo; s <= hi; s++) begin
         if (pipe[s].v && pipe[s].wen && pipe[s].rd == r && r != 0) return s;
      end
      return 0;
   endfunction

   function automatic logic late_load(int s);
      if (s == 0) return 1'b0;
      return pipe[s].ld && (s < LOAD_READY);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model at the falling edge.
   task automatic settle();
      int   fa, fb;
      logic ba, bb;
      @(negedge clk);
      n_vec++;
      fa = (pipe[1].v && pipe[1].u1) ? producer(pipe[1].rs1, 2, DEPTH) : 0;
      fb = (pipe[1].v && pipe[1].u2) ? producer(pipe[1].rs2, 2, DEPTH) : 0;
      e_stall = late_load(fa) || late_load(fb);
      e_flush = redirect && !e_stall;
      ba = dec_valid && dec_uses_rs1 && (producer(dec_rs1, DEPTH, DEPTH) != 0);
      bb = dec_valid && dec_uses_rs2 && (producer(dec_rs2, DEPTH, DEPTH) != 0);
      chk("ex_fwd_a", 32'(ex_fwd_a), 32'(fa));
      chk("ex_fwd_b", 32'(ex_fwd_b), 32'(fb));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("flush_dec", 32'(flush_dec), 32'(e_flush));
      chk("dec_byp_a", 32'(dec_byp_a), 32'(ba));
      chk("dec_byp_b", 32'(dec_byp_b), 32'(bb));
      chk("stall_count", stall_count, m_stall_cnt);
      chk("flush_count", flush_count, m_flush_cnt);
   endtask

   // Advance the model across the rising edge.
   task automatic tick();
      ins_t nop;
      @(posedge clk);
      nop = '{v: 1'b0, rd: '0, wen: 1'b0, ld: 1'b0, rs1: '0, rs2: '0, u1: 1'b0, u2: 1'b0};
      if (rst) begin
         for (int s = 1; s <= DEPTH; s++) pipe[s] = nop;
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (e_stall) m_stall_cnt++;
         if (e_flush) m_flush_cnt++;
         for (int s = DEPTH; s >= 3; s--) pipe[s] = pipe[s-1];
         if (e_stall) begin
            pipe[2] = nop;
         end else begin
            pipe[2] = pipe[1];
            pipe[1] = '{v: dec_valid && !e_flush, rd: dec_rd, wen: dec_wen, ld: dec_is_load,
                        rs1: dec_rs1, rs2: dec_rs2, u1: dec_uses_rs1, u2: dec_uses_rs2};
         end
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drv(logic v, logic [REG_AW-1:0] rd, logic wen, logic ld,
                      logic [REG_AW-1:0] rs1, logic u1, logic [REG_AW-1:0] rs2, logic u2);
      rst          = 1'b0;
      redirect     = 1'b0;
      dec_valid    = v;
      dec_rd       = rd;
      dec_wen      = wen;
      dec_is_load  = ld;
      dec_rs1      = rs1;
      dec_uses_rs1 = u1;
      dec_rs2      = rs2;
      dec_uses_rs2 = u2;
   endtask

   task automatic nop_in();
      drv(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic do_reset();
      nop_in();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0;
      n_fail = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
      for (int s = 1; s <= DEPTH; s++) pipe[s].v = 1'b0;
      nop_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      nop_in();
      settle();
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_fwd_a", 32'(ex_fwd_a), 32'd0);
      chk("reset_cnt", stall_count, 32'd0);
      tick();

      // ALU-ALU back to back: add x5,x1,x2 ; add x6,x5,x3
      do_reset();
      drv(1, 5, 1, 0, 1, 1, 2, 1); step();
      drv(1, 6, 1, 0, 5, 1, 3, 1); step();
      nop_in(); settle();
      chk("alu_fwd_a", 32'(ex_fwd_a), 32'd2);
      chk("alu_fwd_b", 32'(ex_fwd_b), 32'd0);
      chk("alu_stall", 32'(stall), 32'd0);
      tick();

      // Load-use: lw x5 ; add x6,x5,x0
      do_reset();
      drv(1, 5, 1, 1, 1, 1, 0, 0); step();
      drv(1, 6, 1, 0, 5, 1, 0, 1); step();
      nop_in(); settle();
      chk("lu_stall", 32'(stall), 32'd1);
      chk("lu_fwd_a", 32'(ex_fwd_a), 32'd2);
      tick();
      settle();
      chk("lu_after_fwd_a", 32'(ex_fwd_a), 32'd3);
      chk("lu_after_stall", 32'(stall), 32'd0);
      chk("lu_stall_count", stall_count, 32'd1);
      tick();

      // x0 is never forwarded
      do_reset();
      drv(1, 0, 1, 0, 1, 1, 0, 0); step();
      drv(1, 6, 1, 0, 0, 1, 0, 0); step();
      nop_in(); settle();
      chk("x0_fwd_a", 32'(ex_fwd_a), 32'd0);
      tick();

      // Youngest producer wins
      do_reset();
      drv(1, 5, 1, 0, 1, 1, 2, 1); step();
      drv(1, 5, 1, 0, 3, 1, 4, 1); step();
      drv(1, 6, 1, 0, 5, 1, 0, 0); step();
      nop_in(); settle();
      chk("prio_fwd_a", 32'(ex_fwd_a), 32'd2);
      tick();

      // Redirect without stall flushes decode
      do_reset();
      drv(1, 5, 1, 0, 1, 1, 2, 1); step();
      drv(1, 6, 1, 0, 5, 1, 0, 0);
      redirect = 1'b1;
      settle();
      chk("redir_flush", 32'(flush_dec), 32'd1);
      tick();
      nop_in(); settle();
      chk("redir_fwd_a", 32'(ex_fwd_a), 32'd0);
      chk("redir_count", flush_count, 32'd1);
      tick();

      // Redirect during stall is ignored
      do_reset();
      drv(1, 5, 1, 1, 1, 1, 0, 0); step();
      drv(1, 6, 1, 0, 5, 1, 0, 0); step();
      nop_in();
      redirect = 1'b1;
      settle();
      chk("redir_stall_flush", 32'(flush_dec), 32'd0);
      tick();
      nop_in(); settle();
      chk("redir_stall_count", flush_count, 32'd0);
      tick();

      // WB write-through bypass, then the same with rd = x0
      for (int k = 0; k < 2; k++) begin
         do_reset();
         drv(1, (k == 0) ? 5'd7 : 5'd0, 1, 0, 1, 1, 2, 1); step();
         nop_in(); step();
         nop_in(); step();
         drv(1, 9, 1, 0, 3, 1, (k == 0) ? 5'd7 : 5'd0, 1); settle();
         chk("wb_byp_a", 32'(dec_byp_a), 32'd0);
         chk("wb_byp_b", 32'(dec_byp_b), (k == 0) ? 32'd1 : 32'd0);
         tick();
      end

      // Reset asserted mid-stall
      do_reset();
      drv(1, 5, 1, 1, 1, 1, 0, 0); step();
      drv(1, 6, 1, 0, 5, 1, 5, 1); step();
      nop_in();
      rst = 1'b1;
      settle();
      chk("rst_mid_stall_before", 32'(stall), 32'd1);
      tick();
      nop_in(); settle();
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_fwd_a", 32'(ex_fwd_a), 32'd0);
      chk("rst_mid_fwd_b", 32'(ex_fwd_b), 32'd0);
      chk("rst_mid_scnt", stall_count, 32'd0);
      chk("rst_mid_fcnt", flush_count, 32'd0);
      tick();

      // Randomized traffic over a small register range to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         drv($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         redirect = ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
